// File: rtl/oam_dma_if.sv
// rtl/oam_dma_if.sv - CPU bus / DMA engine signal bundle for oam_dma
interface oam_dma_if;
    logic        cpu_ce;
    logic        odd_cycle;
    logic [15:0] bus_addr;
    logic [7:0]  bus_din;
    logic        bus_wr;
    logic [7:0]  mem_rdata;
    logic        dma_hijack;
    logic [15:0] dma_addr;
    logic        dma_wr;
    logic [7:0]  dma_wdata;
    logic        dma_done;

    modport master (
        output cpu_ce, odd_cycle, bus_addr, bus_din, bus_wr, mem_rdata,
        input  dma_hijack, dma_addr, dma_wr, dma_wdata, dma_done
    );

    modport slave (
        input  cpu_ce, odd_cycle, bus_addr, bus_din, bus_wr, mem_rdata,
        output dma_hijack, dma_addr, dma_wr, dma_wdata, dma_done
    );
endinterface

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite OAM DMA engine: copies one 256-byte CPU page into the PPU OAM port
module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] OAM_PORT     = 16'h2004
) (
    input  logic ppu_clk,
    input  logic reset,
    oam_dma_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] page, page_nx;
    logic [7:0] idx, idx_nx;
    logic [7:0] data, data_nx;
    logic       hijack, hijack_nx;
    logic       trigger;

    assign trigger = bus.cpu_ce && bus.bus_wr && (bus.bus_addr == TRIGGER_ADDR);

    always_comb begin
        state_nx = state;
        page_nx  = page;
        idx_nx   = idx;
        data_nx  = data;
        case (state)
            IDLE: begin
                if (trigger) begin
                    page_nx  = bus.bus_din;
                    state_nx = HALT;
                end
            end
            HALT: begin
                if (bus.cpu_ce) state_nx = bus.odd_cycle ? ALIGN : READ;
            end
            ALIGN: begin
                if (bus.cpu_ce) state_nx = READ;
            end
            READ: begin
                if (bus.cpu_ce) begin
                    data_nx  = bus.mem_rdata;
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (bus.cpu_ce) begin
                    idx_nx   = idx + 8'd1;
                    state_nx = (idx == 8'hFF) ? DONE : READ;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Hijack is registered, so it follows the state we are about to enter.
        hijack_nx = (state_nx == HALT) || (state_nx == ALIGN) ||
                    (state_nx == READ) || (state_nx == WRITE);
    end

    always_ff @(posedge ppu_clk) begin
        if (reset) begin
            state  <= IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            data   <= 8'h00;
            hijack <= 1'b0;
        end else begin
            state  <= state_nx;
            page   <= page_nx;
            idx    <= idx_nx;
            data   <= data_nx;
            hijack <= hijack_nx;
        end
    end

    assign bus.dma_hijack = hijack;
    assign bus.dma_addr   = (state == READ)  ? {page, idx} :
                            (state == WRITE) ? OAM_PORT    : 16'h0000;
    assign bus.dma_wr     = (state == WRITE);
    assign bus.dma_wdata  = (state == WRITE) ? data : 8'h00;
    assign bus.dma_done   = (state == DONE);
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter TRIGGER_ADDR, default 16'h4014: CPU write address that starts a transfer.
REQ-002 Parameter OAM_PORT, default 16'h2004: PPU OAM data register that receives each DMA write.
REQ-003 ppu_clk  in  1  Block clock; all state changes on its rising edge.
REQ-004 reset  in  1  Reset, synchronous, active-high; clock ppu_clk.
REQ-005 cpu_ce  in  1  One-ppu_clk strobe marking the end of each CPU cycle.
REQ-006 odd_cycle  in  1  CPU cycle parity, sampled with cpu_ce; 1 means the current cycle is odd.
REQ-007 bus_addr  in  16  CPU bus address.
REQ-008 bus_din  in  8  CPU write data.
REQ-009 bus_wr  in  1  CPU write strobe.
REQ-010 mem_rdata  in  8  CPU memory read data for the current dma_addr, valid at cpu_ce.
REQ-011 dma_hijack  out  1  High while the DMA engine owns the bus and the CPU is stalled.
REQ-012 dma_addr  out  16  Bus address driven by the DMA engine.
REQ-013 dma_wr  out  1  DMA write strobe.
REQ-014 dma_wdata  out  8  DMA write data.
REQ-015 dma_done  out  1  Single-ppu_clk pulse when a transfer completes.

Function
REQ-016 The FSM SHALL use states IDLE, HALT, ALIGN, READ, WRITE, and DONE, and SHALL advance only on ppu_clk edges where cpu_ce=1, except for DONE.
REQ-017 In IDLE, the block SHALL latch page=bus_din and go to HALT when cpu_ce, bus_wr, and bus_addr==TRIGGER_ADDR are all 1 on the same edge.
REQ-018 When leaving HALT on cpu_ce, the FSM SHALL go to ALIGN if odd_cycle=1, otherwise to READ.
REQ-019 ALIGN SHALL last exactly one CPU cycle and then go to READ.
REQ-020 In READ, the outputs SHALL be dma_addr={page,idx} and dma_wr=0; on cpu_ce the block SHALL latch data=mem_rdata and go to WRITE.
REQ-021 In WRITE, the outputs SHALL be dma_addr=OAM_PORT, dma_wr=1, and dma_wdata=data; on cpu_ce the block SHALL set idx=idx+1 (8-bit).
REQ-022 On leaving WRITE, the FSM SHALL go to DONE if idx was 8'hFF before the increment, otherwise to READ; idx wraps to 0.
REQ-023 DONE SHALL last one ppu_clk, SHALL assert dma_done=1, and SHALL go to IDLE without waiting for cpu_ce.
REQ-024 dma_hijack SHALL be 1 in HALT, ALIGN, READ, and WRITE, and 0 in IDLE and DONE; it is a registered output.
REQ-025 A transfer SHALL hold dma_hijack high for exactly 513 CPU cycles when odd_cycle=0 at the HALT exit, and 514 when it is 1.
REQ-026 In IDLE, HALT, ALIGN, and DONE, the outputs SHALL be dma_wr=0, dma_addr=16'h0000, and dma_wdata=8'h00.
REQ-027 Trigger writes while the state is not IDLE SHALL be ignored, and page SHALL stay unchanged.
REQ-028 A trigger on the same edge that DONE returns to IDLE SHALL be ignored; a trigger on the next cpu_ce SHALL be accepted.
REQ-029 A page value of 8'hFF SHALL read addresses 16'hFF00 through 16'hFFFF with no carry into the upper byte.
REQ-030 The block SHALL issue exactly 256 writes to OAM_PORT per transfer, in ascending source-address order.

Reset
REQ-031 On a ppu_clk edge with reset=1, the block SHALL set state=IDLE, page=0, idx=0, data=0, dma_hijack=0, dma_wr=0, dma_addr=0, dma_wdata=0, and dma_done=0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no dma_done pulse and no further writes, and dma_hijack SHALL be low on the edge after reset.
REQ-033 Reset SHALL take priority over a trigger write on the same edge.

Verification
REQ-034 Write 8'h02 to 16'h4014 with odd_cycle=0 at HALT exit, mem_rdata=low byte of address -> 256 writes to 16'h2004 of data 00..FF, hijack high for 513 CPU cycles, one dma_done pulse.
REQ-035 Same stimulus with odd_cycle=1 at HALT exit -> hijack high for 514 CPU cycles and an identical write sequence.
REQ-036 Page 8'hFF -> the first read address is 16'hFF00, the last is 16'hFFFF, and no address reaches 16'h0000.
REQ-037 Second write of 8'h05 to 16'h4014 during a transfer of page 8'h03 -> all reads stay at 16'h03xx, and exactly 256 writes occur.
REQ-038 Reset asserted after the 100th write -> hijack drops on the next edge, no more writes and no dma_done; a new trigger of 8'h07 then runs a full transfer from 16'h0700.
REQ-039 cpu_ce held at 0 for 10 ppu_clk during READ -> state, dma_addr, and idx hold, and the transfer resumes correctly when cpu_ce returns.
